wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file for the 8-bit pipelined processor, directly downstream of the EX/WB pipeline register. Each cycle it selects the value to write from the EX/WB fields (ALU result, immediate or link PC) and commits it to a 32-entry × 8-bit register file. It serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass. It also exports the writeback value for EX-stage forwarding and keeps a retired-write counter.

## Interface
- DATA_W, 8, data/PC width
- ADDR_W, 5, register address width
- NUM_REGS, 32, register count (2^ADDR_W)
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  single clock; all state updates on posedge
- Reset  in  1  synchronous, active-low
- PCnew_EX_WB  in  DATA_W  link PC for jump instructions
- ResultALU_EX_WB  in  DATA_W  ALU result
- imm_EX_WB  in  DATA_W  immediate value
- RegRd_EX_WB  in  ADDR_W  destination register
- RegWrite_EX_WB  in  1  write enable
- jumpIns_EX_WB  in  1  selects PCnew as write data
- valueToReg_EX_WB  in  1  selects imm as write data
- RegRs1  in  ADDR_W  read port 1 address (from decode)
- RegRs2  in  ADDR_W  read port 2 address
- ReadData1  out  DATA_W  read port 1 data
- ReadData2  out  DATA_W  read port 2 data
- WBData  out  DATA_W  selected writeback value, for EX forwarding
- WBValid  out  1  a real register write commits this cycle
- RetireCount  out  CNT_W  number of committed writes

## Operation
- Reset handling: clk and Reset are fixed; Reset is synchronous and active-low.
- Write-data select, combinational, in priority order:
  - jumpIns_EX_WB=1 → PCnew_EX_WB
  - else valueToReg_EX_WB=1 → imm_EX_WB
  - else ResultALU_EX_WB
- Both flags set: jump wins.
- WBData = selected value at all times, including when no write occurs.
- WBValid = Reset & RegWrite_EX_WB & (RegRd_EX_WB != 0).
- Register 0 is hardwired to 0. Writes to it are discarded and do not count as retired.
- Commit: at posedge clk with WBValid=1, regs[RegRd_EX_WB] <= WBData and RetireCount <= RetireCount+1.
- RetireCount wraps modulo 2^CNT_W: 0xFFFF → 0x0000.
- Read port n, combinational, in priority order:
  - Reset=0 → 0
  - RegRsn=0 → 0
  - WBValid and RegRd_EX_WB=RegRsn → WBData (bypass)
  - else regs[RegRsn]
- Both read ports are independent. Both may hit the bypass in the same cycle.

## Timing
- Reset: at a posedge with Reset=0, all 32 registers and RetireCount clear to 0.
- While Reset=0: ReadData1/2=0 and WBValid=0 combinationally; WBData still reflects the select mux. No write or count occurs at that edge, even if RegWrite_EX_WB=1.
- Reset deasserted mid-stream: the first commit happens at the first posedge with Reset=1. The EX/WB contents present at that edge are honoured.
- Write latency: the value is visible through the bypass in the same cycle it is presented. It is held in regs from the next posedge onward.
- Read latency: 0 cycles (combinational). No read/write hazard exists within this block.
- Back-to-back writes to the same Rd in consecutive cycles: the last one wins. Each write increments RetireCount.
- There is no stall or handshake. The block consumes one EX/WB entry every cycle.

## Test plan
- Reset: preload r5=0x3C and RetireCount=7, then hold Reset=0 for one edge with RegWrite=1, Rd=5, ALU=0x99. Required: r5=0, RetireCount=0, ReadData1(Rs1=5)=0 during and after the reset edge.
- Source select: Rd=3, RegWrite=1, ALU=0x11, imm=0x22, PC=0x33.
  - flags (jump, val) = 00 → r3=0x11
  - 01 → 0x22
  - 10 → 0x33
  - 11 → 0x33
  - RetireCount advances by 4.
- Register 0: RegWrite=1, Rd=0, ALU=0xFF. Required: WBValid=0, ReadData1(Rs1=0)=0, RetireCount unchanged, WBData=0xFF.
- Bypass: r7=0x10 committed, then present Rd=7, ALU=0x5A, RegWrite=1 with Rs1=Rs2=7. Required: same cycle ReadData1=ReadData2=0x5A; after the edge, with RegWrite=0, ReadData1=0x5A.
- No-write: RegWrite=0, Rd=9, ALU=0xAB with Rs1=9 where r9=0x04. Required: ReadData1=0x04 before and after the edge, WBValid=0.
- Counter wrap: drive 65536 valid writes from reset. Required: RetireCount=0xFFFF after 65535 writes, 0x0000 after 65536.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage and 32x8 architectural register file with two combinational
// read ports, same-cycle write-to-read bypass and a retired-write counter.
module wb_regfile #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] PCnew_EX_WB,
    input  logic [DATA_W-1:0] ResultALU_EX_WB,
    input  logic [DATA_W-1:0] imm_EX_WB,
    input  logic [ADDR_W-1:0] RegRd_EX_WB,
    input  logic              RegWrite_EX_WB,
    input  logic              jumpIns_EX_WB,
    input  logic              valueToReg_EX_WB,
    input  logic [ADDR_W-1:0] RegRs1,
    input  logic [ADDR_W-1:0] RegRs2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WBData,
    output logic              WBValid,
    output logic [CNT_W-1:0]  RetireCount
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  retire_count_reg;
    logic [ADDR_W-1:0] rs_addr [2];
    logic [DATA_W-1:0] rs_data [2];

    // Jump link PC has priority over the immediate, which beats the ALU result.
    always_comb begin
        WBData = ResultALU_EX_WB;
        if (jumpIns_EX_WB) begin
            WBData = PCnew_EX_WB;
        end else if (valueToReg_EX_WB) begin
            WBData = imm_EX_WB;
        end
    end

    assign WBValid = Reset & RegWrite_EX_WB & (RegRd_EX_WB != '0);

    // Entry 0 is never written (WBValid excludes Rd=0) and reads of it are masked.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            retire_count_reg <= '0;
        end else if (WBValid) begin
            regs[RegRd_EX_WB] <= WBData;
            retire_count_reg  <= retire_count_reg + CNT_W'(1);
        end
    end

    assign rs_addr[0] = RegRs1;
    assign rs_addr[1] = RegRs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rs_data[gi] = regs[rs_addr[gi]];
                if (!Reset || rs_addr[gi] == '0) begin
                    rs_data[gi] = '0;
                end else if (WBValid && RegRd_EX_WB == rs_addr[gi]) begin
                    rs_data[gi] = WBData;
                end
            end
        end
    endgenerate

    assign ReadData1   = rs_data[0];
    assign ReadData2   = rs_data[1];
    assign RetireCount = retire_count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expected outputs from an
// array/counter model, a negedge monitor pops and compares.
module tb_wb_regfile;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] PCnew_EX_WB = '0, ResultALU_EX_WB = '0, imm_EX_WB = '0;
    logic [4:0] RegRd_EX_WB = '0, RegRs1 = '0, RegRs2 = '0;
    logic       RegWrite_EX_WB = 1'b0, jumpIns_EX_WB = 1'b0, valueToReg_EX_WB = 1'b0;
    logic [7:0] ReadData1, ReadData2, WBData;
    logic       WBValid;
    logic [15:0] RetireCount;

    wb_regfile dut (
        .clk(clk), .Reset(Reset),
        .PCnew_EX_WB(PCnew_EX_WB), .ResultALU_EX_WB(ResultALU_EX_WB),
        .imm_EX_WB(imm_EX_WB), .RegRd_EX_WB(RegRd_EX_WB),
        .RegWrite_EX_WB(RegWrite_EX_WB), .jumpIns_EX_WB(jumpIns_EX_WB),
        .valueToReg_EX_WB(valueToReg_EX_WB), .RegRs1(RegRs1), .RegRs2(RegRs2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WBData(WBData),
        .WBValid(WBValid), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [7:0]  rd1;
        logic [7:0]  rd2;
        logic [7:0]  wbd;
        logic        wbv;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;
    int          txn_id = 0;
    logic [7:0]  m_regs [32];
    int unsigned m_cnt = 0;

    function automatic logic [7:0] model_read(input logic rst, input logic [4:0] a,
                                              input logic wbv, input logic [4:0] rd,
                                              input logic [7:0] sel);
        if (!rst || a == 0) return 8'h00;
        if (wbv && rd == a) return sel;
        return m_regs[a];
    endfunction

    task automatic drive(input logic rst, input logic we, input logic j, input logic v,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [7:0] alu, input logic [7:0] imm, input logic [7:0] pc,
                         input bit chk);
        exp_t       e;
        logic [7:0] sel;
        logic       wbv;
        @(posedge clk);
        #1;
        Reset = rst; RegWrite_EX_WB = we; jumpIns_EX_WB = j; valueToReg_EX_WB = v;
        RegRd_EX_WB = rd; RegRs1 = rs1; RegRs2 = rs2;
        ResultALU_EX_WB = alu; imm_EX_WB = imm; PCnew_EX_WB = pc;
        sel = j ? pc : (v ? imm : alu);
        wbv = rst && we && (rd != 0);
        if (chk) begin
            e.id  = txn_id;
            e.rd1 = model_read(rst, rs1, wbv, rd, sel);
            e.rd2 = model_read(rst, rs2, wbv, rd, sel);
            e.wbd = sel;
            e.wbv = wbv;
            e.cnt = 16'(m_cnt);
            sb.push_back(e);
            txn_id++;
        end
        // Effect of the upcoming posedge on the architectural state
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
            m_cnt = 0;
        end else if (wbv) begin
            m_regs[rd] = sel;
            m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    task automatic wr(input logic [4:0] rd, input logic [7:0] alu, input logic [4:0] rs1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, rd, rs1, rs1, alu, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic rnd(input bit chk, input bit allow_reset);
        logic rst;
        rst = allow_reset ? ($urandom_range(0, 31) != 0) : 1'b1;
        drive(rst, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
              5'($urandom), 5'($urandom), 5'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom), chk);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            bit   bad;
            e = sb.pop_front();
            bad = 1'b0;
            checks += 5;
            if (ReadData1 !== e.rd1) begin
                failures++; bad = 1'b1;
                $display("FAIL rd1 txn=%0d got=%02h exp=%02h", e.id, ReadData1, e.rd1);
            end
            if (ReadData2 !== e.rd2) begin
                failures++; bad = 1'b1;
                $display("FAIL rd2 txn=%0d got=%02h exp=%02h", e.id, ReadData2, e.rd2);
            end
            if (WBData !== e.wbd) begin
                failures++; bad = 1'b1;
                $display("FAIL wbdata txn=%0d got=%02h exp=%02h", e.id, WBData, e.wbd);
            end
            if (WBValid !== e.wbv) begin
                failures++; bad = 1'b1;
                $display("FAIL wbvalid txn=%0d got=%0b exp=%0b", e.id, WBValid, e.wbv);
            end
            if (RetireCount !== e.cnt) begin
                failures++; bad = 1'b1;
                $display("FAIL retire txn=%0d got=%04h exp=%04h", e.id, RetireCount, e.cnt);
            end
            if (!bad)
                $display("txn %0d ok rd1=%02h rd2=%02h wb=%02h v=%0b cnt=%04h",
                         e.id, e.rd1, e.rd2, e.wbd, e.wbv, e.cnt);
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL timeout pending=%0d exp=0", sb.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
        // Initial reset; state before the first edge is unknown
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 5'd4, 5'd0, 8'h12, 8'h00, 8'h00, 1'b1);

        // Reset scenario: r5=0x3C and seven retired writes, then a reset edge
        wr(5'd5, 8'h3C, 5'd5);
        for (int i = 1; i <= 6; i++) wr(5'(i + 10), 8'(i * 7), 5'd5);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 8'h99, 8'h00, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd11, 8'h99, 8'h00, 8'h00, 1'b1);

        // Source select priority, Rd=3
        for (int f = 0; f < 4; f++)
            drive(1'b1, 1'b1, 1'(f >> 1), 1'(f & 1), 5'd3, 5'd3, 5'd0, 8'h11, 8'h22, 8'h33, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd3, 5'd3, 8'h00, 8'h00, 8'h00, 1'b1);

        // Register 0 write is discarded
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'hFF, 8'h00, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 8'h00, 8'h00, 8'h00, 1'b1);

        // Bypass on both ports
        wr(5'd7, 8'h10, 5'd0);
        wr(5'd7, 8'h5A, 5'd7);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 8'h00, 8'h00, 8'h00, 1'b1);

        // No-write: r9 keeps its value
        wr(5'd9, 8'h04, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 8'hAB, 8'h00, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 8'hAB, 8'h00, 8'h00, 1'b1);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 300; n++) rnd(1'b1, 1'b1);

        // Counter wrap: 65536 valid writes from reset
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int n = 1; n <= 65536; n++)
            drive(1'b1, 1'b1, 1'b0, 1'b0, 5'($urandom_range(1, 31)), 5'($urandom),
                  5'($urandom), 8'($urandom), 8'h00, 8'h00, (n >= 65535));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd2, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int n = 0; n < 20; n++) rnd(1'b1, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
